// File: rtl/alu_issue_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stampflow_sched_pkg
// Purpose  : Shared sizes, FSM state type and slot helper for the ALU issue
//            scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package stampflow_sched_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;
    localparam int STAMP_W   = 3;
    localparam int WDOG_MAX  = 255;
    localparam int WDOG_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERR   = 2'd3
    } sched_state_t;

    // Expand a slot index into a one-hot slot vector.
    function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] idx);
        logic [NUM_SLOTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_scheduler_if
// Purpose  : Slot-conveyor / ALU issue bundle. The master modport is the
//            scheduler; the slave modport is the conveyor + ALU side.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_scheduler_if;
    import stampflow_sched_pkg::*;

    logic [NUM_SLOTS-1:0]         slot_valid;
    logic [NUM_SLOTS-1:0]         slot_ready;
    logic [NUM_SLOTS*STAMP_W-1:0] slot_stamp_flat;
    logic [STAMP_W-1:0]           head_stamp;
    logic                         flush;
    logic                         alu_ready;
    logic                         alu_done;
    logic                         issue_valid;
    logic [SLOT_W-1:0]            issue_slot;
    logic [STAMP_W-1:0]           issue_stamp;
    logic [NUM_SLOTS-1:0]         slot_take;
    logic                         busy;
    logic                         err;
    logic [15:0]                  issue_count;

    modport master (
        input  slot_valid, slot_ready, slot_stamp_flat, head_stamp,
               flush, alu_ready, alu_done,
        output issue_valid, issue_slot, issue_stamp, slot_take,
               busy, err, issue_count
    );

    modport slave (
        output slot_valid, slot_ready, slot_stamp_flat, head_stamp,
               flush, alu_ready, alu_done,
        input  issue_valid, issue_slot, issue_stamp, slot_take,
               busy, err, issue_count
    );

endinterface
`default_nettype wire

// File: rtl/alu_issue_scheduler_oldest_ready_picker.sv
`default_nettype none
// ============================================================================
// Module   : oldest_ready_picker
// Purpose  : Selects the candidate slot whose stamp is closest to the head
//            stamp (modular age); ties go to the lowest slot index.
// Revision : 1.0 - initial release
// ============================================================================
module oldest_ready_picker
    import stampflow_sched_pkg::*;
(
    input  logic [NUM_SLOTS-1:0]         cand,
    input  logic [NUM_SLOTS*STAMP_W-1:0] stamps,
    input  logic [STAMP_W-1:0]           head_stamp,
    output logic                         found,
    output logic [SLOT_W-1:0]            index
);

    logic [STAMP_W-1:0] w_age;
    logic [STAMP_W-1:0] w_best;

    // Linear scan; strict less-than keeps the lower index on equal age.
    always_comb begin
        found  = 1'b0;
        index  = '0;
        w_best = '0;
        w_age  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_age = stamps[i*STAMP_W +: STAMP_W] - head_stamp;
            if (cand[i] && (!found || (w_age < w_best))) begin
                found  = 1'b1;
                index  = SLOT_W'(i);
                w_best = w_age;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_scheduler
// Purpose  : Picks the oldest ready slot, presents it to the ALU, waits for
//            writeback, and guards the wait with a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_scheduler
    import stampflow_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    alu_issue_scheduler_if.master bus
);

    sched_state_t         r_state;
    logic                 r_issue_valid;
    logic [SLOT_W-1:0]    r_issue_slot;
    logic [STAMP_W-1:0]   r_issue_stamp;
    logic                 r_busy;
    logic                 r_err;
    logic [15:0]          r_issue_count;
    logic [WDOG_W-1:0]    r_wdog;

    logic [NUM_SLOTS-1:0] w_mask;
    logic [NUM_SLOTS-1:0] w_cand;
    logic                 w_found;
    logic [SLOT_W-1:0]    w_pick;
    logic [STAMP_W-1:0]   w_pick_stamp;
    logic                 w_handshake;

    // The slot just written back is still visible on the conveyor during the
    // alu_done cycle, so it is hidden from the picker for that cycle only.
    always_comb begin
        w_mask = '0;
        if ((r_state == ST_WAIT) && bus.alu_done)
            w_mask = slot_onehot(r_issue_slot);
        w_cand = bus.slot_valid & bus.slot_ready & ~w_mask;
    end

    oldest_ready_picker u_picker (
        .cand       (w_cand),
        .stamps     (bus.slot_stamp_flat),
        .head_stamp (bus.head_stamp),
        .found      (w_found),
        .index      (w_pick)
    );

    // Fetch the stamp of the picked slot for capture.
    always_comb begin
        w_pick_stamp = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_pick == SLOT_W'(i))
                w_pick_stamp = bus.slot_stamp_flat[i*STAMP_W +: STAMP_W];
        end
    end

    // Handshake is suppressed by flush and reset; slot_take follows it directly.
    always_comb begin
        w_handshake   = (r_state == ST_ISSUE) && r_issue_valid && bus.alu_ready
                        && !bus.flush && !reset;
        bus.slot_take = w_handshake ? slot_onehot(r_issue_slot) : '0;
    end

    // Issue FSM with registered outputs, issue counter and WAIT watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_issue_valid <= 1'b0;
            r_issue_slot  <= '0;
            r_issue_stamp <= '0;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
            r_issue_count <= '0;
            r_wdog        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!bus.flush && w_found) begin
                        r_state       <= ST_ISSUE;
                        r_issue_valid <= 1'b1;
                        r_busy        <= 1'b1;
                        r_issue_slot  <= w_pick;
                        r_issue_stamp <= w_pick_stamp;
                    end
                end
                ST_ISSUE: begin
                    if (bus.flush) begin
                        r_state       <= ST_IDLE;
                        r_issue_valid <= 1'b0;
                        r_busy        <= 1'b0;
                    end else if (w_handshake) begin
                        r_state       <= ST_WAIT;
                        r_issue_valid <= 1'b0;
                        r_issue_count <= r_issue_count + 16'd1;
                        r_wdog        <= '0;
                    end
                end
                ST_WAIT: begin
                    if (bus.flush) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_wdog  <= '0;
                    end else if (bus.alu_done) begin
                        r_wdog <= '0;
                        if (w_found) begin
                            r_state       <= ST_ISSUE;
                            r_issue_valid <= 1'b1;
                            r_issue_slot  <= w_pick;
                            r_issue_stamp <= w_pick_stamp;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (r_wdog == WDOG_W'(WDOG_MAX - 1)) begin
                        r_state <= ST_ERR;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_wdog  <= r_wdog + 8'd1;
                    end else begin
                        r_wdog <= r_wdog + 8'd1;
                    end
                end
                ST_ERR: begin
                    r_issue_valid <= 1'b0;
                    r_busy        <= 1'b0;
                    r_err         <= 1'b1;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_issue_valid <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.issue_valid = r_issue_valid;
    assign bus.issue_slot  = r_issue_slot;
    assign bus.issue_stamp = r_issue_stamp;
    assign bus.busy        = r_busy;
    assign bus.err         = r_err;
    assign bus.issue_count = r_issue_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_scheduler
// Purpose  : Directed self-checking bench for alu_issue_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_scheduler;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu_issue_scheduler_if bus ();

    alu_issue_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle just after the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_stamp(input int idx, input logic [2:0] v);
        bus.slot_stamp_flat[idx*3 +: 3] = v;
    endtask

    task automatic clear_slots();
        bus.slot_valid      = 8'h00;
        bus.slot_ready      = 8'h00;
        bus.slot_stamp_flat = 24'h0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        clear_slots();
        bus.head_stamp = 3'd0;
        bus.flush      = 1'b0;
        bus.alu_ready  = 1'b0;
        bus.alu_done   = 1'b0;
        cyc(1);

        // Reset dominates live candidates, alu_ready, alu_done and flush.
        bus.slot_valid = 8'hFF;
        bus.slot_ready = 8'hFF;
        bus.alu_ready  = 1'b1;
        bus.alu_done   = 1'b1;
        bus.flush      = 1'b1;
        cyc(2);
        chk("rst_issue_valid", 16'(bus.issue_valid), 16'd0);
        chk("rst_issue_slot",  16'(bus.issue_slot),  16'd0);
        chk("rst_issue_stamp", 16'(bus.issue_stamp), 16'd0);
        chk("rst_slot_take",   16'(bus.slot_take),   16'h00);
        chk("rst_busy",        16'(bus.busy),        16'd0);
        chk("rst_err",         16'(bus.err),         16'd0);
        chk("rst_count",       bus.issue_count,      16'd0);
        reset = 1'b0;
        clear_slots();
        bus.alu_ready = 1'b0;
        bus.alu_done  = 1'b0;
        bus.flush     = 1'b0;
        cyc(1);
        chk("idle_no_cand", 16'(bus.issue_valid), 16'd0);

        // Slots 2 (stamp 4) and 5 (stamp 1), head 0 -> slot 5.
        bus.slot_valid = 8'h24;
        bus.slot_ready = 8'h24;
        set_stamp(2, 3'd4);
        set_stamp(5, 3'd1);
        cyc(1);
        chk("p1_valid", 16'(bus.issue_valid), 16'd1);
        chk("p1_slot",  16'(bus.issue_slot),  16'd5);
        chk("p1_stamp", 16'(bus.issue_stamp), 16'd1);
        chk("p1_busy",  16'(bus.busy),        16'd1);
        chk("p1_take_nordy", 16'(bus.slot_take), 16'h00);
        bus.alu_ready = 1'b1;
        #1;
        chk("p1_take", 16'(bus.slot_take), 16'h20);
        cyc(1);
        chk("p1_count", bus.issue_count, 16'd1);
        chk("p1_wait_valid", 16'(bus.issue_valid), 16'd0);
        chk("p1_wait_busy",  16'(bus.busy), 16'd1);
        bus.alu_ready = 1'b0;
        clear_slots();
        bus.alu_done = 1'b1;
        cyc(1);
        bus.alu_done = 1'b0;
        chk("p1_done_idle", 16'(bus.busy), 16'd0);

        // Wrap-around: head 6, slot 1 stamp 7 (age 1), slot 6 stamp 2 (age 4).
        bus.head_stamp = 3'd6;
        bus.slot_valid = 8'h42;
        bus.slot_ready = 8'h42;
        set_stamp(1, 3'd7);
        set_stamp(6, 3'd2);
        cyc(1);
        chk("p2_slot",  16'(bus.issue_slot),  16'd1);
        chk("p2_stamp", 16'(bus.issue_stamp), 16'd7);
        bus.alu_ready = 1'b1;
        #1;
        chk("p2_take", 16'(bus.slot_take), 16'h02);
        cyc(1);
        chk("p2_count", bus.issue_count, 16'd2);
        bus.alu_ready = 1'b0;
        clear_slots();
        bus.head_stamp = 3'd0;
        bus.alu_done = 1'b1;
        cyc(1);
        bus.alu_done = 1'b0;

        // Hold: alu_ready low for 10 cycles while slot_valid toggles and an
        // older slot 7 comes and goes; the presentation must not move.
        bus.slot_valid = 8'h01;
        bus.slot_ready = 8'h81;
        set_stamp(0, 3'd3);
        set_stamp(7, 3'd0);
        cyc(1);
        chk("p3_slot0", 16'(bus.issue_slot), 16'd0);
        for (int i = 0; i < 10; i++) begin
            bus.slot_valid = (i % 2 == 0) ? 8'h80 : 8'h81;
            cyc(1);
            chk("p3_hold_slot",  16'(bus.issue_slot),  16'd0);
            chk("p3_hold_stamp", 16'(bus.issue_stamp), 16'd3);
            chk("p3_hold_valid", 16'(bus.issue_valid), 16'd1);
            chk("p3_hold_take",  16'(bus.slot_take),   16'h00);
        end

        // Flush together with alu_ready: no take, no count, IDLE next.
        bus.flush     = 1'b1;
        bus.alu_ready = 1'b1;
        clear_slots();
        #1;
        chk("p4_flush_take", 16'(bus.slot_take), 16'h00);
        cyc(1);
        bus.flush     = 1'b0;
        bus.alu_ready = 1'b0;
        chk("p4_flush_valid", 16'(bus.issue_valid), 16'd0);
        chk("p4_flush_busy",  16'(bus.busy),        16'd0);
        chk("p4_flush_count", bus.issue_count,      16'd2);

        // Slot 3 (stamp 0) then slot 4 (stamp 1); slot 3 masked on alu_done.
        bus.slot_valid = 8'h18;
        bus.slot_ready = 8'h18;
        set_stamp(3, 3'd0);
        set_stamp(4, 3'd1);
        cyc(1);
        chk("p5_slot3", 16'(bus.issue_slot), 16'd3);
        bus.alu_ready = 1'b1;
        #1;
        chk("p5_take3", 16'(bus.slot_take), 16'h08);
        cyc(1);
        bus.alu_ready = 1'b0;
        bus.alu_done  = 1'b1;
        chk("p5_count", bus.issue_count, 16'd3);
        cyc(1);
        bus.alu_done = 1'b0;
        chk("p5_next_valid", 16'(bus.issue_valid), 16'd1);
        chk("p5_next_slot",  16'(bus.issue_slot),  16'd4);
        chk("p5_next_stamp", 16'(bus.issue_stamp), 16'd1);
        bus.alu_ready = 1'b1;
        clear_slots();
        cyc(1);
        bus.alu_ready = 1'b0;
        chk("p5_count2", bus.issue_count, 16'd4);

        // Watchdog: WAIT entered at the last edge; 255 WAIT cycles -> ERR.
        cyc(254);
        chk("wd_not_yet_err",  16'(bus.err),  16'd0);
        chk("wd_not_yet_busy", 16'(bus.busy), 16'd1);
        cyc(1);
        chk("wd_err",   16'(bus.err),         16'd1);
        chk("wd_valid", 16'(bus.issue_valid), 16'd0);
        chk("wd_busy",  16'(bus.busy),        16'd0);
        bus.slot_valid = 8'h04;
        bus.slot_ready = 8'h04;
        bus.alu_done   = 1'b1;
        bus.flush      = 1'b1;
        cyc(1);
        bus.alu_done = 1'b0;
        bus.flush    = 1'b0;
        cyc(2);
        bus.alu_ready = 1'b1;
        #1;
        chk("err_sticky",  16'(bus.err),         16'd1);
        chk("err_novalid", 16'(bus.issue_valid), 16'd0);
        chk("err_notake",  16'(bus.slot_take),   16'h00);
        chk("err_count",   bus.issue_count,      16'd4);
        bus.alu_ready = 1'b0;

        // Reset leaves ERR.
        clear_slots();
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("rst2_err",   16'(bus.err),    16'd0);
        chk("rst2_count", bus.issue_count, 16'd0);

        // Equal age tie (slots 4 and 6, stamp 5, head 5) -> lower index 4.
        bus.head_stamp = 3'd5;
        bus.slot_valid = 8'h50;
        bus.slot_ready = 8'h50;
        set_stamp(4, 3'd5);
        set_stamp(6, 3'd5);
        cyc(1);
        chk("tie_slot",  16'(bus.issue_slot),  16'd4);
        chk("tie_stamp", 16'(bus.issue_stamp), 16'd5);

        // Valid but not ready slot is not a candidate after flush to IDLE.
        bus.flush = 1'b1;
        bus.slot_ready = 8'h00;
        cyc(1);
        bus.flush = 1'b0;
        cyc(1);
        chk("notready_idle", 16'(bus.issue_valid), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_scheduler.md
ALU_ISSUE_SCHEDULER -- requirements
Module: alu_issue_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 slot_valid  in  8  slot i holds a decoded command.
REQ-005 slot_ready  in  8  slot i operands available (ALU-runnable list).
REQ-006 slot_stamp_flat  in  24  3-bit stamp of slot i at bits [3i+2:3i].
REQ-007 head_stamp  in  3  stamp of oldest in-flight command.
REQ-008 flush  in  1  cancel current selection/outstanding op.
REQ-009 alu_ready  in  1  ALU accepts the presented command.
REQ-010 alu_done  in  1  single-cycle pulse: ALU writeback (rd write) complete.
REQ-011 issue_valid  out  1  presented command valid.
REQ-012 issue_slot  out  3  index of presented slot.
REQ-013 issue_stamp  out  3  stamp of presented slot.
REQ-014 slot_take  out  8  one-hot pulse: slot consumed, conveyor clears it.
REQ-015 busy  out  1  high in ISSUE or WAIT.
REQ-016 err  out  1  sticky watchdog error.
REQ-017 issue_count  out  16  number of completed handshakes, wraps at 65535->0.

Function
REQ-018 Candidate i SHALL be slot_valid[i] & slot_ready[i] & ~mask[i], mask = one-hot of last issued slot during the cycle alu_done is sampled, else zero.
REQ-019 Age SHALL be (stamp_i - head_stamp) mod 8; the candidate with smallest age is selected, ties broken by lowest index.
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, ERR.
REQ-021 IDLE: any candidate -> ISSUE next cycle, capturing issue_slot/issue_stamp; else stay.
REQ-022 ISSUE: issue_valid=1; issue_slot/issue_stamp held stable until handshake (issue_valid & alu_ready).
REQ-023 On handshake SHALL: slot_take[issue_slot]=1 same cycle (combinational), issue_count+1, -> WAIT.
REQ-024 WAIT: alu_done with candidate -> ISSUE (new capture); alu_done without candidate -> IDLE; alu_done outside WAIT ignored.
REQ-025 Watchdog SHALL count cycles in WAIT from 0 on entry; reaching 255 without alu_done -> ERR.
REQ-026 ERR: err=1, issue_valid=0, slot_take=0; left only by reset.
REQ-027 flush in IDLE/ISSUE/WAIT SHALL force IDLE next cycle; flush overrides handshake same cycle (no slot_take, no count increment); flush ignored in ERR.
REQ-028 slot_valid dropping for captured slot during ISSUE SHALL NOT cancel presentation; only flush cancels.
REQ-029 Minimum issue interval SHALL be 2 cycles (ISSUE, WAIT with immediate alu_done).

Reset
REQ-030 Reset SHALL set state=IDLE, issue_valid=0, issue_slot=0, issue_stamp=0, slot_take=0, busy=0, err=0, issue_count=0, watchdog=0, mask=0.
REQ-031 Reset SHALL take priority over flush, alu_done and handshake in the same cycle; reset mid-WAIT discards the outstanding op.

Structure
REQ-032 Package stampflow_sched_pkg SHALL hold NUM_SLOTS=8, SLOT_W=3, STAMP_W=3, WDOG_MAX=255 and the FSM state enum.
REQ-033 Age comparison SHALL be one combinational sub-module oldest_ready_picker (inputs candidate mask, stamps, head_stamp; outputs found, index).

Verification
REQ-034 Slots 2,5 valid+ready, stamps 4,1, head 0 -> ISSUE picks slot 5 (stamp 1); with alu_ready=1 slot_take=8'h20, issue_count=1.
REQ-035 Slots 1,6 ready, stamps 7,2, head 6 -> slot 1 selected (age 1 vs 4), stamp wrap-around.
REQ-036 alu_ready held 0 for 10 cycles, slot_valid toggled -> issue_slot/issue_stamp unchanged, slot_take=0 throughout.
REQ-037 flush and alu_ready both 1 in ISSUE -> no slot_take, count unchanged, IDLE next cycle.
REQ-038 WAIT with no alu_done for 255 cycles -> err=1, issue_valid=0; later candidates ignored until reset; reset clears err.
REQ-039 alu_done one cycle after handshake on slot 3, slot 3 still valid, slot 4 ready -> next issue_slot=4.
